// File: rtl/op_arb_pkg.sv
// op_arb_pkg: opcode and FSM state enums plus default operand width shared by op_unit_arbiter.
package op_arb_pkg;
   localparam int DEF_WIDTH = 4;
   typedef enum logic [2:0] {
      OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_RED_AND, OP_RED_OR, OP_PASS_A
   } op_e;
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_e;
endpackage

// File: rtl/op_alu.sv
// op_alu: combinational bitwise/arithmetic/reduction unit; flag is carry (ADD) or borrow (SUB).
module op_alu import op_arb_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  op_e              op,
   output logic [WIDTH-1:0] result,
   output logic             flag
);
   logic [WIDTH:0] w_sum, w_dif;
   assign w_sum = {1'b0, a} + {1'b0, b};
   assign w_dif = {1'b0, a} - {1'b0, b};
   always_comb begin
      result = '0;
      flag   = 1'b0;
      case (op)
         OP_AND:     result = a & b;
         OP_OR:      result = a | b;
         OP_XOR:     result = a ^ b;
         OP_ADD:     {flag, result} = w_sum;
         OP_SUB:     {flag, result} = w_dif;
         OP_RED_AND: result = {{(WIDTH-1){1'b0}}, &a};
         OP_RED_OR:  result = {{(WIDTH-1){1'b0}}, |a};
         OP_PASS_A:  result = a;
      endcase
   end
endmodule

// File: rtl/op_unit_arbiter.sv
// op_unit_arbiter: round-robin share of one op_alu between two valid/ready requesters.
// Optional grant counters are built when OP_ARB_STATS_EN is defined.
module op_unit_arbiter import op_arb_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH
`ifdef OP_ARB_STATS_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [2:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [2:0]       req1_op,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             res_flag,
   output logic             res_id
`ifdef OP_ARB_STATS_EN
   , output logic [CNT_W-1:0] grant_cnt0
   , output logic [CNT_W-1:0] grant_cnt1
`endif
);
   state_e           r_state;
   logic             r_ptr, r_id, r_res_valid, r_res_flag, r_res_id;
   logic [WIDTH-1:0] r_a, r_b, r_res_data;
   op_e              r_op;
   logic             w_idle, w_g0, w_g1, w_flag;
   logic [WIDTH-1:0] w_res;

   assign w_idle = r_state == ST_IDLE;
   // requester 1 wins when alone or when it holds the priority pointer
   assign w_g1 = w_idle && req1_valid && (!req0_valid || r_ptr);
   assign w_g0 = w_idle && req0_valid && !w_g1;
   assign req0_ready = w_g0 && !RST;
   assign req1_ready = w_g1 && !RST;
   assign res_valid = r_res_valid;
   assign res_data = r_res_data;
   assign res_flag = r_res_flag;
   assign res_id = r_res_id;

   op_alu #(.WIDTH(WIDTH)) u_alu (.a(r_a), .b(r_b), .op(r_op), .result(w_res), .flag(w_flag));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= ST_IDLE;
         r_ptr       <= 1'b0;
         r_id        <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_op        <= OP_AND;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_flag  <= 1'b0;
         r_res_id    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (w_g0 || w_g1) begin
               r_a     <= w_g1 ? req1_a : req0_a;
               r_b     <= w_g1 ? req1_b : req0_b;
               r_op    <= op_e'(w_g1 ? req1_op : req0_op);
               r_id    <= w_g1;
               r_ptr   <= !w_g1;
               r_state <= ST_EXEC;
            end
            ST_EXEC: begin
               r_res_data  <= w_res;
               r_res_flag  <= w_flag;
               r_res_id    <= r_id;
               r_res_valid <= 1'b1;
               r_state     <= ST_DONE;
            end
            ST_DONE: if (res_ready) begin
               r_res_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef OP_ARB_STATS_EN
   logic [CNT_W-1:0] r_cnt0, r_cnt1;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         if (w_g0 && r_cnt0 != '1) r_cnt0 <= r_cnt0 + CNT_W'(1);
         if (w_g1 && r_cnt1 != '1) r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
   end
   assign grant_cnt0 = r_cnt0;
   assign grant_cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_op_unit_arbiter.sv
// tb_op_unit_arbiter: vector table, hand sequences and a randomized run against a transaction-level model.
module tb_op_unit_arbiter;
   logic       CLK = 1'b0, RST = 1'b1;
   logic       req0_valid = 0, req1_valid = 0, res_ready = 0;
   logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
   logic [2:0] req0_op = 0, req1_op = 0;
   logic       req0_ready, req1_ready, res_valid, res_flag, res_id;
   logic [3:0] res_data;
`ifdef OP_ARB_STATS_EN
   logic [7:0] grant_cnt0, grant_cnt1;
`endif
   int n_chk = 0, n_err = 0;

   op_unit_arbiter dut (
      .CLK(CLK), .RST(RST),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_flag(res_flag), .res_id(res_id)
`ifdef OP_ARB_STATS_EN
      , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {int r; int a; int b; int op; int d; int f;} vec_t;
   vec_t tv[12];

   task automatic adv();
      @(posedge CLK);
      #1;
   endtask

   task automatic mid();
      @(negedge CLK);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_req(input int r, input logic v, input int a, input int b, input int op);
      if (r == 0) begin
         req0_valid = v; req0_a = a[3:0]; req0_b = b[3:0]; req0_op = op[2:0];
      end else begin
         req1_valid = v; req1_a = a[3:0]; req1_b = b[3:0]; req1_op = op[2:0];
      end
   endtask

   task automatic do_reset();
      RST = 1'b1;
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      adv();
      RST = 1'b0;
   endtask

   function automatic void ref_alu(input int a, input int b, input int op, output int d, output int f);
      f = 0;
      case (op)
         0: d = a & b;
         1: d = a | b;
         2: d = a ^ b;
         3: begin d = (a + b) % 16; f = (a + b) > 15 ? 1 : 0; end
         4: begin d = (a - b + 16) % 16; f = a < b ? 1 : 0; end
         5: d = a == 15 ? 1 : 0;
         6: d = a != 0 ? 1 : 0;
         default: d = a;
      endcase
   endfunction

   int m_age, m_prio, m_id, m_d, m_f, w;
   int rv[2], ra[2], rb[2], rop[2];
   logic rr;

   initial begin
      tv[0]  = '{0, 5, 3, 0, 1, 0};
      tv[1]  = '{1, 15, 1, 3, 0, 1};
      tv[2]  = '{0, 2, 5, 4, 13, 1};
      tv[3]  = '{1, 4, 0, 6, 1, 0};
      tv[4]  = '{0, 7, 0, 5, 0, 0};
      tv[5]  = '{1, 15, 0, 5, 1, 0};
      tv[6]  = '{0, 10, 5, 1, 15, 0};
      tv[7]  = '{1, 12, 10, 2, 6, 0};
      tv[8]  = '{0, 3, 4, 3, 7, 0};
      tv[9]  = '{1, 9, 4, 4, 5, 0};
      tv[10] = '{0, 6, 9, 7, 6, 0};
      tv[11] = '{1, 0, 7, 6, 0, 0};

      // reset state
      mid();
      chk("rst_rdy0", req0_ready, 0);
      chk("rst_rdy1", req1_ready, 0);
      chk("rst_rv", res_valid, 0);
      chk("rst_data", res_data, 0);
      chk("rst_flag", res_flag, 0);
      chk("rst_id", res_id, 0);
      adv();
      RST = 1'b0;
      res_ready = 1'b1;

      for (int i = 0; i < 12; i++) begin
         set_req(tv[i].r, 1, tv[i].a, tv[i].b, tv[i].op);
         mid();
         chk("tv_rdy", tv[i].r ? req1_ready : req0_ready, 1);
         chk("tv_rdy_other", tv[i].r ? req0_ready : req1_ready, 0);
         adv();
         set_req(tv[i].r, 0, 0, 0, 0);
         mid();
         chk("tv_exec_rv", res_valid, 0);
         adv();
         mid();
         chk("tv_rv", res_valid, 1);
         chk("tv_data", res_data, tv[i].d);
         chk("tv_flag", res_flag, tv[i].f);
         chk("tv_id", res_id, tv[i].r);
         adv();
      end

      // both requesters continuously valid: grants alternate every 3 cycles
      do_reset();
      set_req(0, 1, 1, 2, 3);
      set_req(1, 1, 3, 1, 4);
      for (int c = 0; c < 12; c++) begin
         mid();
         chk("alt_rdy0", req0_ready, (c % 3 == 0) && ((c / 3) % 2 == 0));
         chk("alt_rdy1", req1_ready, (c % 3 == 0) && ((c / 3) % 2 == 1));
         chk("alt_rv", res_valid, c % 3 == 2);
         if (c % 3 == 2) chk("alt_id", res_id, (c / 3) % 2);
         adv();
      end
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);

      // result stalled in DONE blocks grants
      res_ready = 1'b0;
      set_req(0, 1, 9, 3, 3);
      mid();
      chk("stall_grant", req0_ready, 1);
      adv();
      set_req(0, 1, 1, 1, 1);
      set_req(1, 1, 2, 2, 2);
      mid();
      chk("stall_exec_rdy", req0_ready | req1_ready, 0);
      adv();
      for (int c = 0; c < 5; c++) begin
         mid();
         chk("stall_rv", res_valid, 1);
         chk("stall_data", res_data, 12);
         chk("stall_id", res_id, 0);
         chk("stall_rdy", {req1_ready, req0_ready}, 0);
         adv();
      end
      res_ready = 1'b1;
      mid();
      chk("stall_rel_rdy", {req1_ready, req0_ready}, 0);
      adv();
      mid();
      chk("stall_after_rdy1", req1_ready, 1);
      chk("stall_after_rdy0", req0_ready, 0);
      chk("stall_after_rv", res_valid, 0);
      adv();
      set_req(0, 0, 0, 0, 0);
      set_req(1, 0, 0, 0, 0);
      repeat (3) adv();

      // reset during EXEC discards the transaction
      set_req(0, 1, 15, 15, 0);
      mid();
      chk("abort_grant", req0_ready, 1);
      adv();
      set_req(0, 0, 0, 0, 0);
      #2 RST = 1'b1;
      #1;
      chk("abort_rv", res_valid, 0);
      chk("abort_data", res_data, 0);
      chk("abort_flag", res_flag, 0);
      chk("abort_id", res_id, 0);
      mid();
      RST = 1'b0;
      for (int c = 0; c < 4; c++) begin
         adv();
         mid();
         chk("abort_no_res", res_valid, 0);
      end
      adv();

      // randomized run against a transaction-level model
      do_reset();
      m_age = -1;
      m_prio = 0;
      m_id = 0; m_d = 0; m_f = 0;
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < 2; r++) begin
            rv[r] = $urandom_range(0, 1);
            ra[r] = $urandom_range(0, 15);
            rb[r] = $urandom_range(0, 15);
            rop[r] = $urandom_range(0, 7);
            set_req(r, rv[r][0], ra[r], rb[r], rop[r]);
         end
         rr = $urandom_range(0, 3) != 0;
         res_ready = rr;
         mid();
         w = -1;
         if (m_age < 0) w = (rv[0] != 0 && rv[1] != 0) ? m_prio : rv[0] != 0 ? 0 : rv[1] != 0 ? 1 : -1;
         chk("rnd_rdy0", req0_ready, w == 0);
         chk("rnd_rdy1", req1_ready, w == 1);
         chk("rnd_rv", res_valid, m_age >= 2);
         if (m_age >= 2) begin
            chk("rnd_data", res_data, m_d);
            chk("rnd_flag", res_flag, m_f);
            chk("rnd_id", res_id, m_id);
         end
         if (w >= 0) begin
            ref_alu(ra[w], rb[w], rop[w], m_d, m_f);
            m_id = w;
            m_prio = 1 - w;
            m_age = 1;
         end else if (m_age == 1) m_age = 2;
         else if (m_age >= 2 && rr) m_age = -1;
         adv();
      end

`ifdef OP_ARB_STATS_EN
      do_reset();
      chk("cnt0_rst", grant_cnt0, 0);
      res_ready = 1'b1;
      set_req(0, 1, 1, 1, 0);
      repeat (900) adv();
      set_req(0, 0, 0, 0, 0);
      mid();
      chk("cnt0_sat", grant_cnt0, 255);
      chk("cnt1_zero", grant_cnt1, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/op_unit_arbiter.md
# op_unit_arbiter

Round-robin scheduler that shares one 4-bit logic/arithmetic operation unit between two requesters. Each requester presents operands and an opcode under a valid/ready handshake. The arbiter grants one requester, executes the operation in a registered stage, and returns the result tagged with the requester ID on a valid/ready result port. It sits between the lab's operand sources and the combinational reduction/bitwise datapath, and serialises access to that datapath.

## Interface
Parameters:
- WIDTH, 4, operand/result width
- CNT_W, 8, width of grant counters (stats build only)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  3  requester 0 opcode
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  WIDTH  result
- res_flag  out  1  carry (ADD) / borrow (SUB); 0 for other ops
- res_id  out  1  requester that issued the result
- grant_cnt0, grant_cnt1  out  CNT_W  per-requester grant counts (stats build only)

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB (a-b), 5 RED_AND (&a), 6 RED_OR (|a), 7 PASS_A.
- Reduction results are zero-extended to WIDTH (bit 0 = reduction value).
- ADD/SUB are computed at WIDTH+1 bits. Bit WIDTH goes to res_flag: carry for ADD, borrow=1 when a<b for SUB. The result wraps modulo 2^WIDTH.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: if any reqN_valid, grant one requester. Raise its reqN_ready combinationally in the same cycle, latch a/b/op/id, and go to EXEC. Otherwise stay in IDLE.
  - EXEC: compute the operation and register res_data/res_flag/res_id, set res_valid, go to DONE.
  - DONE: hold all res_* stable while res_valid=1 and res_ready=0. When res_ready=1, clear res_valid and return to IDLE.
- Arbitration: round-robin with a 1-bit priority pointer.
  - When both requesters are valid, the pointer's requester wins. After every grant, the pointer moves to the other requester.
  - When only one requester is valid, it wins regardless of the pointer, and the pointer still moves to the other requester.
- reqN_ready is asserted only in IDLE, and only to the granted requester. It is never asserted to both requesters in the same cycle.
- An unknown opcode cannot occur, because all 8 codes are defined.
- Reset value of every output: req0_ready=0, req1_ready=0, res_valid=0, res_data=0, res_flag=0, res_id=0, grant counters=0. Priority pointer resets to requester 0. State resets to IDLE.
- Reset asserted mid-transaction (EXEC or DONE): the transaction is discarded and never appears on res_*.

## Timing
- Grant to res_valid: 2 cycles. Grant occurs in cycle T (IDLE), EXEC is T+1, and res_valid is high from T+2.
- Best-case throughput is 1 operation per 3 cycles (res_ready held high).
- A result stalled in DONE blocks new grants, and requesters see ready=0.
- A requester may drop valid before it is granted; no grant is issued for a dropped request.

## Configuration
- OP_ARB_STATS_EN defined:
  - grant_cnt0 and grant_cnt1 ports exist.
  - Each counter increments on its requester's grant and saturates at 2^CNT_W-1.
  - Counters clear on RST.
- OP_ARB_STATS_EN undefined: the counter ports and logic are absent, and all other behaviour is identical.

## Structure
- Package op_arb_pkg holds:
  - the opcode enum (OP_AND … OP_PASS_A)
  - the FSM state enum (ST_IDLE, ST_EXEC, ST_DONE)
  - the default WIDTH constant
- Sub-module op_alu: purely combinational. Inputs are a, b, op; outputs are result and flag. Instantiated once, in the EXEC path.

## Test plan
- Reset, then req0 valid with a=4'b0101, b=4'b0011, op=AND -> req0_ready pulses in grant cycle. Two cycles later: res_valid=1, res_data=4'b0001, res_id=0, res_flag=0.
- ADD a=4'hF, b=4'h1 -> res_data=4'h0, res_flag=1. SUB a=4'h2, b=4'h5 -> res_data=4'hD, res_flag=1.
- RED_OR a=4'b0100 -> res_data=4'b0001. RED_AND a=4'b0111 -> res_data=4'b0000.
- Both requesters valid continuously, res_ready=1 -> grants alternate 0,1,0,1. res_id follows the same sequence, and there are 3 cycles between successive grants.
- res_ready held 0 for 5 cycles in DONE -> res_data/res_id stay stable and no reqN_ready is asserted. The grant happens in the cycle after res_ready rises.
- RST asserted during EXEC -> all outputs return to 0 immediately. The aborted result never appears. With OP_ARB_STATS_EN defined, 300 req0 grants -> grant_cnt0 saturates at 255.
